pose_packet_parser: RTL and testbench

Upstream front-end for `game_logic_and_renderer`. It receives the tracker's byte stream, frames and checks 33-byte pose packets, and drives the 15 hand/head coordinate buses. Outputs update atomically, so the game logic never sees a mix of two frames. It also reports link health through a stale flag and saturating packet/error counters.

---
 rtl/pose_packet_parser.sv | 216 +++++++++++++++++++++
 tb/tb_pose_packet_parser.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pose_packet_parser.sv
// pose_packet_parser
//
// Front-end for game_logic_and_renderer. Frames 33-byte pose packets from the
// tracker byte stream (0xA5, 0x5A, 30 payload bytes, XOR checksum), collects
// the payload in a shadow register and copies it to the 15 coordinate buses in
// a single COMMIT cycle, so downstream logic never sees a mix of two frames.
// Link health is reported by a stale flag and saturating good/error counters.
//
// Optional feature macro: POSE_PARSER_CHECKSUM_EN
//   defined   : the checksum byte must equal the XOR of the payload bytes.
//   undefined : the checksum byte is consumed but every packet commits.
//
// Ports:
//   clk_in, rst_in           clock, asynchronous active-low reset
//   byte_in, byte_valid_in   stream byte and its valid strobe
//   byte_ready_out           parser can accept a byte (low in COMMIT/reset)
//   hand_{x,y,z}_*, head_*   committed saber endpoint / head coordinates
//   pose_valid_out           one-cycle pulse when coordinates update
//   stale_out                no good packet within STALE_CYCLES
//   packets_ok_out           saturating good-packet count
//   packet_errors_out        saturating checksum-failure + timeout count
module pose_packet_parser #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int STALE_CYCLES   = 2475000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        byte_ready_out,
    output logic [11:0] hand_x_left_bottom,
    output logic [11:0] hand_y_left_bottom,
    output logic [13:0] hand_z_left_bottom,
    output logic [11:0] hand_x_left_top,
    output logic [11:0] hand_y_left_top,
    output logic [13:0] hand_z_left_top,
    output logic [11:0] hand_x_right_bottom,
    output logic [11:0] hand_y_right_bottom,
    output logic [13:0] hand_z_right_bottom,
    output logic [11:0] hand_x_right_top,
    output logic [11:0] hand_y_right_top,
    output logic [13:0] hand_z_right_top,
    output logic [11:0] head_x,
    output logic [11:0] head_y,
    output logic [13:0] head_z,
    output logic        pose_valid_out,
    output logic        stale_out,
    output logic [15:0] packets_ok_out,
    output logic [7:0]  packet_errors_out
);

    localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_CYCLES);
    localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'(STALE_CYCLES - 1);

    typedef enum logic [2:0] {HUNT_A, HUNT_B, PAYLOAD, CHECK, COMMIT} state_t;

    state_t              state;
    state_t              state_next;
    logic [4:0]          byte_idx;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [STALE_W-1:0]  stale_cnt;
    logic [7:0]          shadow [30];
    logic                xfer;
    logic                timed;
    logic                timeout;
    logic                sum_ok;
    logic                err_inc;

    // Ready is gated by reset so the source sees no acceptance while in reset.
    assign byte_ready_out = rst_in && (state != COMMIT);
    assign xfer           = byte_valid_in && byte_ready_out;
    assign timed          = (state == HUNT_B) || (state == PAYLOAD) || (state == CHECK);
    // The idle cycle that would bring the counter to TIMEOUT_CYCLES aborts the
    // packet; a transfer in that same cycle takes priority.
    assign timeout        = timed && !xfer && (idle_cnt == IDLE_LAST);

`ifdef POSE_PARSER_CHECKSUM_EN
    logic [7:0] run_xor;

    assign sum_ok = (byte_in == run_xor);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            run_xor <= 8'h00;
        end else if (state == HUNT_B && xfer && byte_in == 8'h5A) begin
            run_xor <= 8'h00;
        end else if (state == PAYLOAD && xfer) begin
            run_xor <= run_xor ^ byte_in;
        end
    end
`else
    assign sum_ok = 1'b1;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= HUNT_A;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_inc    = 1'b0;
        case (state)
            HUNT_A:  if (xfer && byte_in == 8'hA5) state_next = HUNT_B;
            HUNT_B: begin
                if (xfer) begin
                    if (byte_in == 8'h5A)      state_next = PAYLOAD;
                    else if (byte_in == 8'hA5) state_next = HUNT_B;
                    else                       state_next = HUNT_A;
                end
            end
            PAYLOAD: if (xfer && byte_idx == 5'd29) state_next = CHECK;
            CHECK: begin
                if (xfer) begin
                    if (sum_ok) begin
                        state_next = COMMIT;
                    end else begin
                        state_next = HUNT_A;
                        err_inc    = 1'b1;
                    end
                end
            end
            COMMIT:  state_next = HUNT_A;
            default: state_next = HUNT_A;
        endcase
        if (timeout) begin
            state_next = HUNT_A;
            err_inc    = 1'b1;
        end
    end

    // Payload capture: byte index restarts on each sync, shadow fills in order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            byte_idx <= 5'd0;
            for (int i = 0; i < 30; i++) shadow[i] <= 8'h00;
        end else if (state == HUNT_B && xfer && byte_in == 8'h5A) begin
            byte_idx <= 5'd0;
        end else if (state == PAYLOAD && xfer) begin
            shadow[byte_idx] <= byte_in;
            if (byte_idx != 5'd29) byte_idx <= byte_idx + 5'd1;
        end
    end

    // Idle counter only runs while a packet is in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                          idle_cnt <= '0;
        else if (!timed || xfer || timeout)   idle_cnt <= '0;
        else                                  idle_cnt <= idle_cnt + 1'b1;
    end

    // Stale flag is set out of reset and by the counter reaching its ceiling;
    // only a commit clears it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stale_cnt <= '0;
            stale_out <= 1'b1;
        end else if (state == COMMIT) begin
            stale_cnt <= '0;
            stale_out <= 1'b0;
        end else begin
            if (stale_cnt != STALE_MAX)  stale_cnt <= stale_cnt + 1'b1;
            if (stale_cnt == STALE_LAST) stale_out <= 1'b1;
        end
    end

    // Coordinates and counters; fields are big-endian, high bits discarded.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hand_x_left_bottom  <= '0;
            hand_y_left_bottom  <= '0;
            hand_z_left_bottom  <= '0;
            hand_x_left_top     <= '0;
            hand_y_left_top     <= '0;
            hand_z_left_top     <= '0;
            hand_x_right_bottom <= '0;
            hand_y_right_bottom <= '0;
            hand_z_right_bottom <= '0;
            hand_x_right_top    <= '0;
            hand_y_right_top    <= '0;
            hand_z_right_top    <= '0;
            head_x              <= '0;
            head_y              <= '0;
            head_z              <= '0;
            pose_valid_out      <= 1'b0;
            packets_ok_out      <= 16'h0000;
            packet_errors_out   <= 8'h00;
        end else begin
            pose_valid_out <= (state == COMMIT);
            if (state == COMMIT) begin
                hand_x_left_bottom  <= {shadow[0][3:0],  shadow[1]};
                hand_y_left_bottom  <= {shadow[2][3:0],  shadow[3]};
                hand_z_left_bottom  <= {shadow[4][5:0],  shadow[5]};
                hand_x_left_top     <= {shadow[6][3:0],  shadow[7]};
                hand_y_left_top     <= {shadow[8][3:0],  shadow[9]};
                hand_z_left_top     <= {shadow[10][5:0], shadow[11]};
                hand_x_right_bottom <= {shadow[12][3:0], shadow[13]};
                hand_y_right_bottom <= {shadow[14][3:0], shadow[15]};
                hand_z_right_bottom <= {shadow[16][5:0], shadow[17]};
                hand_x_right_top    <= {shadow[18][3:0], shadow[19]};
                hand_y_right_top    <= {shadow[20][3:0], shadow[21]};
                hand_z_right_top    <= {shadow[22][5:0], shadow[23]};
                head_x              <= {shadow[24][3:0], shadow[25]};
                head_y              <= {shadow[26][3:0], shadow[27]};
                head_z              <= {shadow[28][5:0], shadow[29]};
                if (packets_ok_out != 16'hFFFF) packets_ok_out <= packets_ok_out + 16'd1;
            end
            if (err_inc && packet_errors_out != 8'hFF)
                packet_errors_out <= packet_errors_out + 8'd1;
        end
    end

endmodule

// File: tb/tb_pose_packet_parser.sv
// Testbench for pose_packet_parser: table of directed packets plus hand-written
// sequences for resync, timeout, back-to-back, stale and mid-packet reset.
module tb_pose_packet_parser;

    localparam int TIMEOUT = 20;
    localparam int STALE   = 100;

`ifdef POSE_PARSER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid_in = 1'b0;
    logic        byte_ready_out;
    logic [11:0] hand_x_left_bottom, hand_y_left_bottom;
    logic [13:0] hand_z_left_bottom;
    logic [11:0] hand_x_left_top, hand_y_left_top;
    logic [13:0] hand_z_left_top;
    logic [11:0] hand_x_right_bottom, hand_y_right_bottom;
    logic [13:0] hand_z_right_bottom;
    logic [11:0] hand_x_right_top, hand_y_right_top;
    logic [13:0] hand_z_right_top;
    logic [11:0] head_x, head_y;
    logic [13:0] head_z;
    logic        pose_valid_out;
    logic        stale_out;
    logic [15:0] packets_ok_out;
    logic [7:0]  packet_errors_out;

    pose_packet_parser #(.TIMEOUT_CYCLES(TIMEOUT), .STALE_CYCLES(STALE)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .byte_in(byte_in), .byte_valid_in(byte_valid_in), .byte_ready_out(byte_ready_out),
        .hand_x_left_bottom(hand_x_left_bottom), .hand_y_left_bottom(hand_y_left_bottom),
        .hand_z_left_bottom(hand_z_left_bottom),
        .hand_x_left_top(hand_x_left_top), .hand_y_left_top(hand_y_left_top),
        .hand_z_left_top(hand_z_left_top),
        .hand_x_right_bottom(hand_x_right_bottom), .hand_y_right_bottom(hand_y_right_bottom),
        .hand_z_right_bottom(hand_z_right_bottom),
        .hand_x_right_top(hand_x_right_top), .hand_y_right_top(hand_y_right_top),
        .hand_z_right_top(hand_z_right_top),
        .head_x(head_x), .head_y(head_y), .head_z(head_z),
        .pose_valid_out(pose_valid_out), .stale_out(stale_out),
        .packets_ok_out(packets_ok_out), .packet_errors_out(packet_errors_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [14:0][15:0] fields;
        logic              corrupt;
    } vec_t;

    int          compared   = 0;
    int          mismatched = 0;
    int          stall_cnt  = 0;
    int          pulses     = 0;
    logic [7:0]  pkt [33];
    logic [15:0] exp_pose [15];
    int          exp_ok  = 0;
    int          exp_err = 0;

    // Independent pulse counter, sampled away from the active edge.
    always @(negedge clk_in) if (pose_valid_out) pulses++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mask_field(input int i, input logic [15:0] v);
        return (i % 3 == 2) ? (v & 16'h3FFF) : (v & 16'h0FFF);
    endfunction

    function automatic void build_packet(input logic [14:0][15:0] f, input logic corrupt);
        logic [7:0] x = 8'h00;
        pkt[0] = 8'hA5;
        pkt[1] = 8'h5A;
        for (int i = 0; i < 15; i++) begin
            pkt[2 + 2*i] = f[i][15:8];
            pkt[3 + 2*i] = f[i][7:0];
            x = x ^ f[i][15:8] ^ f[i][7:0];
        end
        pkt[32] = x ^ {7'b0, corrupt};
    endfunction

    // Presents one byte and returns just after the edge that transfers it.
    task automatic applyStimulus(input logic [7:0] b);
        bit got = 1'b0;
        @(negedge clk_in);
        byte_in       = b;
        byte_valid_in = 1'b1;
        for (int k = 0; k < 4 && !got; k++) begin
            if (byte_ready_out) got = 1'b1;
            else begin
                stall_cnt++;
                @(negedge clk_in);
            end
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ready_wait: got ready=0 for 4 cycles, expected ready=1");
        end
        @(posedge clk_in);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) applyStimulus(pkt[i]);
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        repeat (n) @(posedge clk_in);
    endtask

    task automatic check_pose(input string tag);
        logic [15:0] act [15];
        act[0]  = 16'(hand_x_left_bottom);  act[1]  = 16'(hand_y_left_bottom);
        act[2]  = 16'(hand_z_left_bottom);  act[3]  = 16'(hand_x_left_top);
        act[4]  = 16'(hand_y_left_top);     act[5]  = 16'(hand_z_left_top);
        act[6]  = 16'(hand_x_right_bottom); act[7]  = 16'(hand_y_right_bottom);
        act[8]  = 16'(hand_z_right_bottom); act[9]  = 16'(hand_x_right_top);
        act[10] = 16'(hand_y_right_top);    act[11] = 16'(hand_z_right_top);
        act[12] = 16'(head_x);              act[13] = 16'(head_y);
        act[14] = 16'(head_z);
        for (int i = 0; i < 15; i++)
            checkOutput($sformatf("%s_field%0d", tag, i), {16'h0, act[i]}, {16'h0, exp_pose[i]});
    endtask

    // Called right after the checksum byte transfers; checks the 1-cycle latency.
    task automatic finish_packet(input string tag, input logic [14:0][15:0] f, input bit commit);
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        checkOutput({tag, "_pv_early"}, {31'b0, pose_valid_out}, 32'd0);
        checkOutput({tag, "_ready_commit"}, {31'b0, byte_ready_out}, {31'b0, !commit});
        @(negedge clk_in);
        if (commit) begin
            for (int i = 0; i < 15; i++) exp_pose[i] = mask_field(i, f[i]);
            exp_ok++;
        end else begin
            exp_err++;
        end
        checkOutput({tag, "_pv_pulse"}, {31'b0, pose_valid_out}, {31'b0, commit});
        checkOutput({tag, "_ok_cnt"}, {16'h0, packets_ok_out}, exp_ok);
        checkOutput({tag, "_err_cnt"}, {24'h0, packet_errors_out}, exp_err);
        check_pose(tag);
        if (commit) checkOutput({tag, "_stale"}, {31'b0, stale_out}, 32'd0);
        @(negedge clk_in);
        checkOutput({tag, "_pv_end"}, {31'b0, pose_valid_out}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 15; i++) exp_pose[i] = 16'h0;
        exp_ok  = 0;
        exp_err = 0;
        checkOutput({tag, "_ready"}, {31'b0, byte_ready_out}, 32'd0);
        checkOutput({tag, "_pv"}, {31'b0, pose_valid_out}, 32'd0);
        checkOutput({tag, "_stale"}, {31'b0, stale_out}, 32'd1);
        checkOutput({tag, "_ok"}, {16'h0, packets_ok_out}, 32'd0);
        checkOutput({tag, "_err"}, {24'h0, packet_errors_out}, 32'd0);
        check_pose(tag);
    endtask

    vec_t vecs [4];
    logic [14:0][15:0] f;
    int p0;

    initial begin
        // Directed packet table.
        vecs[0].fields = {15{16'h0001}};
        vecs[0].fields[0] = 16'h0123; vecs[0].fields[1] = 16'h0456; vecs[0].fields[2] = 16'h2ABC;
        vecs[0].corrupt = 1'b0;
        vecs[1] = vecs[0];
        vecs[1].corrupt = 1'b1;
        vecs[2].fields = {15{16'h1234}};
        vecs[2].fields[0] = 16'hFFFF; vecs[2].fields[2] = 16'hFFFF; vecs[2].fields[14] = 16'hC00F;
        vecs[2].corrupt = 1'b0;
        vecs[3].fields = {15{16'hA55A}};
        vecs[3].corrupt = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk_in);
        check_reset_state("reset");
        rst_in = 1'b1;

        for (int v = 0; v < 4; v++) begin
            build_packet(vecs[v].fields, vecs[v].corrupt);
            send_range(0, 32);
            finish_packet($sformatf("vec%0d", v), vecs[v].fields, !(vecs[v].corrupt && CK_EN));
        end

        // Stale after STALE idle cycles since the last commit; pose is held.
        repeat (98) @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("stale_before", {31'b0, stale_out}, 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("stale_set", {31'b0, stale_out}, 32'd1);
        check_pose("stale_hold");
        build_packet(vecs[0].fields, 1'b0);
        send_range(0, 32);
        finish_packet("stale_clear", vecs[0].fields, 1'b1);

        // Leading garbage with double 0xA5 resync and field masking.
        build_packet(vecs[2].fields, 1'b0);
        applyStimulus(8'h00);
        applyStimulus(8'hA5);
        send_range(0, 32);
        finish_packet("resync", vecs[2].fields, 1'b1);
        checkOutput("mask_x", {20'h0, hand_x_left_bottom}, 32'hFFF);
        checkOutput("mask_z", {18'h0, hand_z_left_bottom}, 32'h3FFF);

        // Stall TIMEOUT cycles after payload byte 10: abandoned, outputs held.
        f = {15{16'h0202}};
        build_packet(f, 1'b0);
        send_range(0, 12);
        idle_cycles(TIMEOUT);
        @(negedge clk_in);
        exp_err++;
        checkOutput("timeout_err", {24'h0, packet_errors_out}, exp_err);
        p0 = pulses;
        send_range(13, 32);
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checkOutput("timeout_no_pulse", pulses, p0);
        checkOutput("timeout_ok", {16'h0, packets_ok_out}, exp_ok);
        check_pose("timeout_hold");

        // Stall TIMEOUT-1 cycles: still commits.
        send_range(0, 12);
        idle_cycles(TIMEOUT - 1);
        send_range(13, 32);
        finish_packet("near_timeout", f, 1'b1);

        // Back-to-back with valid held high: ready low one cycle per packet.
        stall_cnt = 0;
        p0 = pulses;
        for (int k = 0; k < 3; k++) begin
            f = {15{16'h0100 + 16'(k)}};
            build_packet(f, 1'b0);
            send_range(0, 32);
            if (k < 2) exp_ok++;
        end
        finish_packet("b2b", f, 1'b1);
        checkOutput("b2b_stalls", stall_cnt, 32'd2);
        checkOutput("b2b_pulses", pulses - p0, 32'd3);

        // Reset asserted mid-packet at payload byte 15.
        f = {15{16'h0777}};
        build_packet(f, 1'b0);
        send_range(0, 17);
        #2;
        rst_in = 1'b0;
        byte_valid_in = 1'b0;
        #1;
        check_reset_state("async_rst");
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        send_range(0, 32);
        finish_packet("post_rst", f, 1'b1);
        f = {15{16'h0345}};
        build_packet(f, 1'b1);
        send_range(0, 32);
        finish_packet("post_rst_bad", f, !CK_EN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
